mpf_uart_transmitter: RTL

- Serialises bytes onto an asynchronous UART line: 1 start bit, 8 data bits LSB first, 1 stop bit, idle high, 115200 baud default.
- Companion to the board UART receiver; drives the same pin pair from the core/debug side.
- Has a one-byte holding register in front of the shift register, so consecutive bytes stream with no idle gap between frames.

---
 rtl/mpf_uart_pkg.sv | 22 ++
 rtl/mpf_uart_baud_counter.sv | 28 ++
 rtl/mpf_uart_transmitter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mpf_uart_pkg.sv
// Shared definitions for the mpf UART transmitter (and its receiver companion).
package mpf_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned FRAME_BITS_NO_PARITY = 10;
  localparam int unsigned FRAME_BITS_PARITY    = 11;

  // Clock cycles per line symbol, truncated toward zero.
  function automatic int unsigned cycles_per_symbol(input int unsigned clk_hz,
                                                    input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/mpf_uart_baud_counter.sv
// Symbol timer: loads CYCLES, counts down to 1; done marks the last cycle of a symbol.
module mpf_uart_baud_counter #(
  parameter int unsigned CYCLES = 217
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int unsigned W = $clog2(CYCLES + 1);

  logic [W-1:0] count_q;

  // Reload on bit entry, otherwise count down and rest at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= W'(CYCLES);
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign done = (count_q == W'(1));

endmodule

// File: rtl/mpf_uart_transmitter.sv
// UART transmitter: 1 start, 8 data LSB first, 1 stop, idle high, with a
// one-byte holding register so back-to-back frames abut.
// Optional even parity bit before stop: define MPF_UART_TX_PARITY_EN.
module mpf_uart_transmitter
  import mpf_uart_pkg::*;
#(
  parameter int unsigned clock_frequency = 25000000,
  parameter int unsigned baud_rate       = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned clock_cycles_in_symbol =
    cycles_per_symbol(clock_frequency, baud_rate);

  generate
    if (clock_cycles_in_symbol < 2) begin : g_bad_cfg
      $error("mpf_uart_transmitter: clock_frequency/baud_rate must be >= 2");
    end
  endgenerate

  uart_state_e state_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_idx_q;
  logic        tx_q;
  logic [7:0]  hold_data_q;
  logic        hold_full_q;
`ifdef MPF_UART_TX_PARITY_EN
  logic        parity_q;
`endif

  logic sym_load;
  logic sym_done;
  logic start_frame;
  logic accept;

  mpf_uart_baud_counter #(
    .CYCLES(clock_cycles_in_symbol)
  ) u_baud (
    .clock(clock),
    .reset(reset),
    .load (sym_load),
    .done (sym_done)
  );

  // Frame start (from idle or straight out of stop), symbol reload and handshake.
  always_comb begin
    start_frame = 1'b0;
    sym_load    = 1'b0;
    accept      = byte_valid & ~hold_full_q;
    if (state_q == IDLE) begin
      start_frame = hold_full_q;
      sym_load    = hold_full_q;
    end else begin
      sym_load = sym_done;
      if (state_q == STOP) start_frame = sym_done & hold_full_q;
    end
  end

  // Frame FSM with registered tx, shift register and holding register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      tx_q        <= 1'b1;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
`ifdef MPF_UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      // Drain and accept are mutually exclusive because ready is !full.
      if (start_frame) hold_full_q <= 1'b0;
      if (accept) begin
        hold_data_q <= byte_data;
        hold_full_q <= 1'b1;
      end

      if (start_frame) begin
        shift_q <= hold_data_q;
`ifdef MPF_UART_TX_PARITY_EN
        parity_q <= ^hold_data_q;
`endif
        state_q <= START;
        tx_q    <= 1'b0;
      end else begin
        case (state_q)
          START: if (sym_done) begin
            state_q   <= DATA;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
          end
          DATA: if (sym_done) begin
            if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef MPF_UART_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= parity_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end
          PARITY: if (sym_done) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
          STOP: if (sym_done) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tx         = tx_q;
  assign byte_ready = ~hold_full_q;
  assign busy       = (state_q != IDLE) | hold_full_q;

endmodule
